// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch stage: PC, imem req/ack, decoder valid/ready, redirect/drain.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/discard_count ports.
module dlx_fetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter int unsigned INC      = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [0:31] instruction,
  output logic [0:31] instr_pc,
  output logic [0:31] pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output logic [0:31] fetch_count,
  output logic [0:31] discard_count,
`endif
  input  logic        redirect,
  input  logic [0:31] redirect_target
);

  typedef enum logic [1:0] {BOOT, FETCH, VALID, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [0:31] pc_q, pc_d;
  logic [0:31] drain_addr_q, drain_addr_d;
  logic [0:31] instruction_q, instruction_d;
  logic [0:31] instr_pc_q, instr_pc_d;
  logic [0:31] pc_plus4_q, pc_plus4_d;
  logic        instr_valid_q, instr_valid_d;
  logic [0:31] target;
  logic        fetch_inc, discard_inc;

  assign target = redirect_target & ~32'h0000_0003;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      drain_addr_q  <= '0;
      instruction_q <= '0;
      instr_pc_q    <= '0;
      pc_plus4_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    instruction_d = instruction_q;
    instr_pc_d    = instr_pc_q;
    pc_plus4_d    = pc_plus4_q;
    instr_valid_d = instr_valid_q;
    fetch_inc     = 1'b0;
    discard_inc   = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect) pc_d = target;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d        = target;
            discard_inc = 1'b1;
          end else begin
            instruction_d = imem_rdata;
            instr_pc_d    = pc_q;
            pc_plus4_d    = pc_q + 32'd4;
            pc_d          = pc_q + 32'(INC);
            instr_valid_d = 1'b1;
            fetch_inc     = 1'b1;
            state_d       = VALID;
          end
        end else if (redirect) begin
          // An outstanding request cannot be withdrawn; remember its address and drain it.
          drain_addr_d = pc_q;
          pc_d         = target;
          state_d      = DRAIN;
        end
      end
      VALID: begin
        if (redirect || instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
        if (redirect) pc_d = target;
      end
      DRAIN: begin
        if (redirect) pc_d = target;
        if (imem_ack) begin
          discard_inc = 1'b1;
          state_d     = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  end

  assign instr_valid = instr_valid_q;
  assign instruction = instruction_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = pc_plus4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [0:31] fetch_count_q, fetch_count_d;
  logic [0:31] discard_count_q, discard_count_d;

  always_comb begin
    fetch_count_d   = fetch_count_q + {31'd0, fetch_inc};
    discard_count_d = discard_count_q + {31'd0, discard_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q   <= '0;
      discard_count_q <= '0;
    end else begin
      fetch_count_q   <= fetch_count_d;
      discard_count_q <= discard_count_d;
    end
  end

  assign fetch_count   = fetch_count_q;
  assign discard_count = discard_count_q;
`else
  logic unused_cnt;
  assign unused_cnt = fetch_inc ^ discard_inc;
`endif

endmodule
